// File: rtl/ctrl_ajuste_campos_pkg.sv
// Shared field codes, FSM encoding and button indices for the date/time
// adjustment front-end.
package ctrl_ajuste_campos_pkg;

    localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
    localparam logic [3:0] CAMPO_SEG     = 4'd1;
    localparam logic [3:0] CAMPO_MIN     = 4'd2;
    localparam logic [3:0] CAMPO_HORA    = 4'd3;
    localparam logic [3:0] CAMPO_DIA     = 4'd4;
    localparam logic [3:0] CAMPO_MES     = 4'd5;
    localparam logic [3:0] CAMPO_ANIO    = 4'd6;

    localparam int BTN_PROG  = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;
    localparam int N_BTN     = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        AJUSTE = 1'b1
    } estado_e;

    // Field navigation wraps inside 1..n; code 0 is never reached from here.
    function automatic logic [3:0] campo_siguiente(input logic [3:0] c, input logic [3:0] n);
        return (c >= n) ? CAMPO_SEG : c + 4'd1;
    endfunction

    function automatic logic [3:0] campo_anterior(input logic [3:0] c, input logic [3:0] n);
        return (c <= CAMPO_SEG) ? n : c - 4'd1;
    endfunction

endpackage

// File: rtl/ctrl_ajuste_campos_antirrebote.sv
// One push-button conditioner: 2-flop synchronizer followed by a counter that
// only lets the debounced level flip after DEB_CYCLES stable samples.
module antirrebote #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DEB_BITS   = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [DEB_BITS-1:0] CNT_MAX = DEB_BITS'(DEB_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DEB_BITS-1:0] cnt_q, cnt_d;
    logic                db_q, db_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        db_d    = db_q;
        // Any sample that agrees with the current level restarts the count.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DEB_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/ctrl_ajuste_campos.sv
// Program/idle controller for the date/time-setting buttons: selects the field
// being adjusted and drives registered up/down adjust levels.
module ctrl_ajuste_campos
    import ctrl_ajuste_campos_pkg::*;
#(
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int DEB_BITS       = 20,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int TO_BITS        = 30,
    parameter int N_CAMPOS       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_prog,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       prog_mode,
    output estado_e    estado_dbg
);

    localparam logic [TO_BITS-1:0] TO_MAX   = TO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         N_CAMPO4 = 4'(N_CAMPOS);

    logic [N_BTN-1:0] raw;
    logic [N_BTN-1:0] db;

    assign raw = {btn_down, btn_up, btn_right, btn_left, btn_prog};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        antirrebote #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_BITS   (DEB_BITS)
        ) u_antirrebote (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (raw[i]),
            .btn_db  (db[i])
        );
    end

    estado_e            estado_q, estado_d;
    logic [3:0]         campo_q, campo_d;
    logic               en_up_q, en_up_d;
    logic               en_down_q, en_down_d;
    logic               prog_mode_q, prog_mode_d;
    logic [TO_BITS-1:0] to_q, to_d;
    logic [2:0]         db_prev_q, db_prev_d;

    logic pulse_prog, pulse_left, pulse_right, timeout_hit;

    always_comb begin
        db_prev_d   = db[BTN_RIGHT:BTN_PROG];
        pulse_prog  = db[BTN_PROG]  & ~db_prev_q[BTN_PROG];
        pulse_left  = db[BTN_LEFT]  & ~db_prev_q[BTN_LEFT];
        pulse_right = db[BTN_RIGHT] & ~db_prev_q[BTN_RIGHT];
        timeout_hit = (to_q == TO_MAX);

        estado_d = estado_q;
        campo_d  = campo_q;
        to_d     = to_q;

        case (estado_q)
            IDLE: begin
                campo_d = CAMPO_NINGUNO;
                if (pulse_prog) begin
                    estado_d = AJUSTE;
                    campo_d  = CAMPO_SEG;
                end
            end
            AJUSTE: begin
                // Exit has priority over navigation; opposing arrows cancel.
                if (pulse_prog || timeout_hit) begin
                    estado_d = IDLE;
                    campo_d  = CAMPO_NINGUNO;
                end else if (pulse_right && !pulse_left) begin
                    campo_d = campo_siguiente(campo_q, N_CAMPO4);
                end else if (pulse_left && !pulse_right) begin
                    campo_d = campo_anterior(campo_q, N_CAMPO4);
                end
            end
        endcase

        if (estado_q == IDLE || (|db)) begin
            to_d = '0;
        end else if (!timeout_hit) begin
            to_d = to_q + TO_BITS'(1);
        end

        // Adjust levels follow the next state so they drop on the exit edge.
        en_up_d     = (estado_d == AJUSTE) && db[BTN_UP] && !db[BTN_DOWN];
        en_down_d   = (estado_d == AJUSTE) && db[BTN_DOWN] && !db[BTN_UP];
        prog_mode_d = (estado_d == AJUSTE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= IDLE;
            campo_q     <= CAMPO_NINGUNO;
            en_up_q     <= 1'b0;
            en_down_q   <= 1'b0;
            prog_mode_q <= 1'b0;
            to_q        <= '0;
            db_prev_q   <= '0;
        end else begin
            estado_q    <= estado_d;
            campo_q     <= campo_d;
            en_up_q     <= en_up_d;
            en_down_q   <= en_down_d;
            prog_mode_q <= prog_mode_d;
            to_q        <= to_d;
            db_prev_q   <= db_prev_d;
        end
    end

    assign en_count   = campo_q;
    assign enUP       = en_up_q;
    assign enDOWN     = en_down_q;
    assign prog_mode  = prog_mode_q;
    assign estado_dbg = estado_q;

endmodule

// File: doc/ctrl_ajuste_campos.md
Name: ctrl_ajuste_campos

Overview:
Front-end controller for the date/time-setting buttons. It debounces five raw push-buttons and runs a program/idle FSM that selects which field is being adjusted. It drives the field-select code `en_count` and the `enUP`/`enDOWN` adjust levels consumed by the per-field 2-digit counters; the month counter responds to code 5. An inactivity timeout returns the block to idle.

Parameters:
DEB_CYCLES, 1_000_000, cycles a synchronized input must hold a new value before the debounced level changes (10 ms at 100 MHz).
DEB_BITS, 20, width of each debounce counter; must satisfy 2^DEB_BITS > DEB_CYCLES.
TIMEOUT_CYCLES, 1_000_000_000, idle cycles in AJUSTE before automatic exit (10 s).
TO_BITS, 30, width of the timeout counter.
N_CAMPOS, 6, number of selectable fields; codes 1..N_CAMPOS.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
btn_prog  in  1  raw button: enter/exit program mode
btn_left  in  1  raw button: previous field
btn_right  in  1  raw button: next field
btn_up  in  1  raw button: increment held
btn_down  in  1  raw button: decrement held
en_count  out  4  field code: 0 = none, 1 s, 2 min, 3 h, 4 day, 5 month, 6 year
enUP  out  1  registered increment level
enDOWN  out  1  registered decrement level
prog_mode  out  1  1 while in AJUSTE

Behaviour:
- Reset (`reset`=0, asynchronous): `en_count`=0, `enUP`=0, `enDOWN`=0, `prog_mode`=0, FSM=IDLE. All synchronizers, debounce counters, debounced levels and the timeout counter are cleared.
- This also applies mid-operation: asserting reset while in AJUSTE with `enUP`=1 drops every output to 0 at once.
- Per button: a 2-flop synchronizer feeds a debounce counter.
  - While the synchronized value differs from the debounced level, the counter increments.
  - When the value matches, the counter clears.
  - When the counter equals DEB_CYCLES-1 and the value still differs, the debounced level toggles on the next edge and the counter clears.
  - Latency from a clean raw edge to the debounced edge is DEB_CYCLES+2 cycles. A glitch shorter than DEB_CYCLES cycles never propagates.
- Rising-edge pulses (one clk wide, the cycle after the debounced rise) are generated for prog, left and right.
- FSM IDLE:
  - `en_count`=0, `prog_mode`=0, `enUP`=`enDOWN`=0.
  - A prog pulse moves to AJUSTE with `en_count`=1.
  - Left, right, up and down are ignored.
- FSM AJUSTE:
  - prog pulse: go to IDLE; `en_count` is 0 on the next edge.
  - right pulse: `en_count` increments; N_CAMPOS wraps to 1.
  - left pulse: `en_count` decrements; 1 wraps to N_CAMPOS.
  - Left and right pulses in the same cycle: no change.
  - prog pulse together with left/right: prog wins and the block exits.
- Adjust outputs (registered, valid only in AJUSTE):
  - `enUP` = up_db AND NOT down_db.
  - `enDOWN` = down_db AND NOT up_db.
  - Both buttons held gives both outputs 0. The outputs are never 1 simultaneously.
  - Both outputs go to 0 on the same edge that the FSM leaves AJUSTE.
- Timeout counter:
  - Clears whenever any debounced level is 1, and in IDLE.
  - Otherwise increments in AJUSTE.
  - On reaching TIMEOUT_CYCLES-1, the FSM goes to IDLE on the next edge.
  - The counter saturates and never wraps.
- All outputs are flops. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds the field codes (CAMPO_NINGUNO=0, CAMPO_SEG=1, CAMPO_MIN=2, CAMPO_HORA=3, CAMPO_DIA=4, CAMPO_MES=5, CAMPO_ANIO=6) and the FSM state encodings (IDLE, AJUSTE).
- One sub-module, `antirrebote`, contains the synchronizer, counter and debounced level, parameterised by DEB_CYCLES/DEB_BITS. It is instantiated five times.
- The FSM, edge detectors and timeout live in the top module.

Test Plan:
(Bench parameters: DEB_CYCLES=4, DEB_BITS=3, TIMEOUT_CYCLES=64, TO_BITS=7.)
1. Reset then btn_prog high for 10 cycles -> `prog_mode`=1 and `en_count`=1 by cycle 8 after the raw edge; outputs are 0 throughout reset.
2. In AJUSTE, btn_right pulsed 5 times then once more -> `en_count` steps 1,2,3,4,5,6,1. Then btn_left once -> 6. A 3-cycle btn_right glitch -> no change.
3. `en_count`=5, btn_up held 20 cycles -> `enUP`=1, `enDOWN`=0 while held. Add btn_down -> both 0. Release btn_up -> `enDOWN`=1.
4. In AJUSTE, no buttons for 64+ cycles -> `en_count`=0 and `prog_mode`=0. Repeat with btn_up held -> no timeout.
5. btn_prog and btn_right asserted on the same cycle in AJUSTE -> exit to IDLE, `en_count`=0.
6. Reset asserted while `enUP`=1 in AJUSTE -> all outputs 0 immediately, before the next clk edge. After release, state is IDLE.
